// File: rtl/imem_loader.sv
// Byte-stream loader for instruction memory.
// Holds the core in reset until a checksum-verified program is written.
module imem_loader #(
   parameter int DW = 32,
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_start,
   input  logic          byte_valid,
   input  logic [7:0]    byte_data,
   output logic          byte_ready,
   output logic          mem_we,
   output logic [AW-1:0] mem_waddr,
   output logic [DW-1:0] mem_wdata,
   output logic          cpu_hold,
   output logic          done,
   output logic          error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN0,
      S_LEN1,
      S_DATA,
      S_WRITE,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [16:0] DEPTH = 17'(1) << AW;

   state_t        state, state_n;
   logic [15:0]   len, len_n;
   logic [16:0]   wcnt, wcnt_n;
   logic [1:0]    bidx, bidx_n;
   logic [7:0]    csum, csum_n;
   logic [AW-1:0] waddr_n;
   logic [DW-1:0] wdata_n;
   logic          ready_n, we_n, hold_n, done_n, err_n;
   logic          xfer;
   logic [15:0]   len_full;

   assign xfer     = byte_valid & byte_ready;
   assign len_full = {byte_data, len[7:0]};

   always_comb begin
      state_n = state;
      len_n   = len;
      wcnt_n  = wcnt;
      bidx_n  = bidx;
      csum_n  = csum;
      waddr_n = mem_waddr;
      wdata_n = mem_wdata;
      unique case (state)
         S_IDLE, S_DONE, S_ERR: begin
            if (load_start) begin
               state_n = S_LEN0;
               waddr_n = '0;
               csum_n  = '0;
               bidx_n  = '0;
               wcnt_n  = '0;
            end
         end
         S_LEN0: begin
            if (xfer) begin
               len_n[7:0] = byte_data;
               state_n    = S_LEN1;
            end
         end
         S_LEN1: begin
            if (xfer) begin
               len_n[15:8] = byte_data;
               if (len_full == 16'd0)
                  state_n = S_CSUM;
               else if ({1'b0, len_full} > DEPTH)
                  state_n = S_ERR;
               else
                  state_n = S_DATA;
            end
         end
         S_DATA: begin
            if (xfer) begin
               wdata_n[{bidx, 3'b000} +: 8] = byte_data;
               csum_n = csum ^ byte_data;
               bidx_n = bidx + 2'd1;
               if (bidx == 2'd3)
                  state_n = S_WRITE;
            end
         end
         S_WRITE: begin
            wcnt_n = wcnt + 17'd1;
            // increment only when another word follows, so the
            // address never wraps past the last written word
            if (wcnt_n < {1'b0, len}) begin
               waddr_n = mem_waddr + AW'(1);
               state_n = S_DATA;
            end else begin
               state_n = S_CSUM;
            end
         end
         S_CSUM: begin
            if (xfer)
               state_n = (byte_data == csum) ? S_DONE : S_ERR;
         end
      endcase
   end

   always_comb begin
      ready_n = (state_n == S_LEN0) || (state_n == S_LEN1) ||
                (state_n == S_DATA) || (state_n == S_CSUM);
      we_n    = (state_n == S_WRITE);
      hold_n  = (state_n != S_DONE);
      done_n  = (state_n == S_DONE);
      err_n   = (state_n == S_ERR);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         len        <= '0;
         wcnt       <= '0;
         bidx       <= '0;
         csum       <= '0;
         mem_waddr  <= '0;
         mem_wdata  <= '0;
         byte_ready <= 1'b0;
         mem_we     <= 1'b0;
         cpu_hold   <= 1'b1;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         state      <= state_n;
         len        <= len_n;
         wcnt       <= wcnt_n;
         bidx       <= bidx_n;
         csum       <= csum_n;
         mem_waddr  <= waddr_n;
         mem_wdata  <= wdata_n;
         byte_ready <= ready_n;
         mem_we     <= we_n;
         cpu_hold   <= hold_n;
         done       <= done_n;
         error      <= err_n;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader.
// A stream-level model predicts writes and outcome; a monitor checks them.
module tb_imem_loader;

   localparam int AW = 8;
   localparam int DEPTH = 1 << AW;

   logic          clk = 0;
   logic          rst = 1;
   logic          load_start = 0;
   logic          byte_valid = 0;
   logic [7:0]    byte_data = 0;
   logic          byte_ready, mem_we, cpu_hold, done, error;
   logic [AW-1:0] mem_waddr;
   logic [31:0]   mem_wdata;

   imem_loader #(.DW(32), .AW(AW)) dut (
      .clk(clk),
      .rst(rst),
      .load_start(load_start),
      .byte_valid(byte_valid),
      .byte_data(byte_data),
      .byte_ready(byte_ready),
      .mem_we(mem_we),
      .mem_waddr(mem_waddr),
      .mem_wdata(mem_wdata),
      .cpu_hold(cpu_hold),
      .done(done),
      .error(error)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]  a;
      logic [31:0] d;
   } wr_t;

   wr_t         exp_q[$];
   wr_t         mon_w;
   logic [31:0] img[DEPTH];
   int          n_chk = 0;
   int          n_fail = 0;
   bit          exp_done, exp_err;
   int          consume;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst && mem_we) begin
         img[mem_waddr] = mem_wdata;
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_write: got addr %h data %h expected none",
                     mem_waddr, mem_wdata);
         end else begin
            mon_w = exp_q.pop_front();
            check("waddr", 32'(mem_waddr), 32'(mon_w.a));
            check("wdata", mem_wdata, mon_w.d);
         end
      end
   end

   // stream-level reference: parse LEN, words, checksum
   task automatic model(input logic [7:0] s[$]);
      int          n;
      logic [7:0]  x;
      logic [31:0] wd;
      n = int'(s[0]) + 256 * int'(s[1]);
      exp_done = 0;
      exp_err  = 0;
      if (n > DEPTH) begin
         exp_err = 1;
         consume = 2;
         return;
      end
      x = 0;
      for (int w = 0; w < n; w++) begin
         wd = {s[2+4*w+3], s[2+4*w+2], s[2+4*w+1], s[2+4*w]};
         x  = x ^ wd[31:24] ^ wd[23:16] ^ wd[15:8] ^ wd[7:0];
         exp_q.push_back('{a: 8'(w), d: wd});
      end
      consume = 2 + 4 * n + 1;
      if (s[consume-1] == x) exp_done = 1;
      else exp_err = 1;
   endtask

   task automatic mk(input int n, input bit good, output logic [7:0] s[$]);
      logic [7:0] x, b;
      x = 0;
      s = {};
      s.push_back(8'(n));
      s.push_back(8'(n >> 8));
      for (int i = 0; i < 4 * n; i++) begin
         b = 8'($urandom);
         s.push_back(b);
         x ^= b;
      end
      s.push_back(good ? x : x ^ 8'($urandom_range(1, 255)));
   endtask

   task automatic send(input logic [7:0] b, input bit gaps);
      int to;
      to = 0;
      byte_data = 8'($urandom);
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      byte_valid = 1;
      byte_data  = b;
      while (!byte_ready && to < 50) begin
         @(negedge clk);
         to++;
      end
      if (to >= 50) begin
         n_chk++;
         n_fail++;
         $display("FAIL byte_timeout: got ready %b expected 1", byte_ready);
      end
      @(negedge clk);
      byte_valid = 0;
   endtask

   task automatic run_load(input logic [7:0] s[$], input bit gaps,
                           input string tag);
      int to;
      @(negedge clk);
      load_start = 1;
      @(negedge clk);
      load_start = 0;
      check({tag, "_start_ready"}, 32'(byte_ready), 1);
      check({tag, "_start_hold"}, 32'(cpu_hold), 1);
      check({tag, "_start_done"}, 32'(done), 0);
      check({tag, "_start_err"}, 32'(error), 0);
      model(s);
      for (int i = 0; i < consume; i++) send(s[i], gaps);
      to = 0;
      while (!(done || error) && to < 100) begin
         @(negedge clk);
         to++;
      end
      check({tag, "_done"}, 32'(done), 32'(exp_done));
      check({tag, "_error"}, 32'(error), 32'(exp_err));
      check({tag, "_hold"}, 32'(cpu_hold), 32'(!exp_done));
      check({tag, "_ready_end"}, 32'(byte_ready), 0);
      check({tag, "_pending"}, exp_q.size(), 0);
   endtask

   logic [7:0] s1[$], s[$];

   initial begin
      s1 = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
             8'h93, 8'h05, 8'h20, 8'h00, 8'hB0};
      #1 rst = 0;
      @(negedge clk);
      check("rst_hold", 32'(cpu_hold), 1);
      check("rst_ready", 32'(byte_ready), 0);
      check("rst_done", 32'(done), 0);
      check("rst_error", 32'(error), 0);
      check("rst_we", 32'(mem_we), 0);
      check("rst_waddr", 32'(mem_waddr), 0);
      rst = 1;

      run_load(s1, 0, "t1");
      check("t1_w0", img[0], 32'h00100513);
      check("t1_w1", img[1], 32'h00200593);

      s = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00};
      run_load(s, 1, "t2");
      check("t2_w0", img[0], 32'hDEADBEEF);

      s = '{8'h01, 8'h01};
      run_load(s, 1, "t3_ovf");

      mk(256, 1, s);
      run_load(s, 0, "t3_full");
      check("t3_last_addr", 32'(mem_waddr), 32'hFF);

      img[0] = 0;
      img[1] = 0;
      run_load(s1, 1, "t4");
      check("t4_w0", img[0], 32'h00100513);
      check("t4_w1", img[1], 32'h00200593);

      for (int k = 0; k < 6; k++) begin
         mk($urandom_range(1, 8), $urandom_range(0, 1) == 1, s);
         run_load(s, 1, "rnd");
      end

      @(negedge clk);
      load_start = 1;
      @(negedge clk);
      load_start = 0;
      send(8'h02, 0);
      send(8'h00, 0);
      send(8'h13, 0);
      send(8'h05, 0);
      @(posedge clk);
      #2 rst = 0;
      #1;
      check("t5_hold", 32'(cpu_hold), 1);
      check("t5_ready", 32'(byte_ready), 0);
      check("t5_we", 32'(mem_we), 0);
      check("t5_waddr", 32'(mem_waddr), 0);
      check("t5_wdata", mem_wdata, 0);
      check("t5_done", 32'(done), 0);
      check("t5_error", 32'(error), 0);
      @(negedge clk);
      rst = 1;
      run_load(s1, 1, "t5_reload");

      s = '{8'h00, 8'h00, 8'h00};
      run_load(s, 0, "t6_empty");
      run_load(s1, 0, "t6_again");

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
